// File: rtl/status_array_arbiter_pkg.sv
// Shared status array geometry used by the arbiter and its environment.
package status_array_arbiter_pkg;

   localparam int unsigned SA_ADDR_WIDTH = 4;
   localparam int unsigned SA_ROW_WIDTH  = 8;
   localparam int unsigned SA_NUM_BLOCKS = 4;

endpackage : status_array_arbiter_pkg

// File: rtl/status_array_arbiter.sv
// Arbitrates a single-port status array between the initializer, status
// updates and lookups; updates win unless a lookup has starved too long.
module status_array_arbiter
   import status_array_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = SA_ADDR_WIDTH,
   parameter int unsigned ROW_WIDTH    = SA_ROW_WIDTH,
   parameter int unsigned NUM_BLOCKS   = SA_NUM_BLOCKS,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_halt,
   input  logic [ADDR_WIDTH-1:0] i_init_addr,
   input  logic [ROW_WIDTH-1:0]  i_init_data,
   input  logic                  i_init_wen,
   input  logic [NUM_BLOCKS-1:0] i_init_wmask,
   input  logic                  i_init_valid,
   input  logic                  i_init_complete,
   input  logic                  i_upd_valid,
   input  logic [ADDR_WIDTH-1:0] i_upd_addr,
   input  logic [ROW_WIDTH-1:0]  i_upd_data,
   input  logic [NUM_BLOCKS-1:0] i_upd_wmask,
   output logic                  o_upd_ready,
   input  logic                  i_lkp_valid,
   input  logic [ADDR_WIDTH-1:0] i_lkp_addr,
   output logic                  o_lkp_ready,
   output logic [ROW_WIDTH-1:0]  o_lkp_rdata,
   output logic                  o_lkp_rvalid,
   output logic [ADDR_WIDTH-1:0] o_sa_addr,
   output logic [ROW_WIDTH-1:0]  o_sa_data,
   output logic                  o_sa_wen,
   output logic [NUM_BLOCKS-1:0] o_sa_wmask,
   output logic                  o_sa_valid,
   input  logic [ROW_WIDTH-1:0]  i_sa_rdata
);

   localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

   typedef enum logic {
      S_INIT = 1'b0,
      S_RUN  = 1'b1
   } state_e;

   state_e              state_q, state_d;
   logic [STARVE_W-1:0] starve_q, starve_d;
   logic                starved_c;
   logic                upd_grant_c, lkp_grant_c;
   logic                rd_issued_q;
   logic                lkp_rvalid_q;

   // Leave init once the initializer reports completion outside a halt.
   always_comb begin
      state_d = state_q;
      if (state_q == S_INIT && i_init_complete && !i_halt) begin
         state_d = S_RUN;
      end
   end

   // Readiness depends only on valids, starvation and state, so grants are exclusive.
   always_comb begin
      starved_c   = (starve_q >= STARVE_W'(STARVE_LIMIT));
      o_upd_ready = 1'b0;
      o_lkp_ready = 1'b0;
      if (state_q == S_RUN && !i_halt) begin
         o_upd_ready = !i_lkp_valid || !starved_c;
         o_lkp_ready = !i_upd_valid || starved_c;
      end
      upd_grant_c = i_upd_valid && o_upd_ready;
      lkp_grant_c = i_lkp_valid && o_lkp_ready;
   end

   // Count update grants that bypass a waiting lookup; saturates at the limit.
   always_comb begin
      starve_d = starve_q;
      if (state_q == S_RUN && !i_halt) begin
         if (lkp_grant_c || !i_lkp_valid) begin
            starve_d = '0;
         end else if (upd_grant_c && !starved_c) begin
            starve_d = starve_q + STARVE_W'(1);
         end
      end
   end

   // State and starvation registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_INIT;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
      end
   end

   // Array command register: init mirror, granted request, or idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_sa_addr  <= '0;
         o_sa_data  <= '0;
         o_sa_wen   <= 1'b0;
         o_sa_wmask <= '0;
         o_sa_valid <= 1'b0;
      end else if (state_q == S_INIT) begin
         o_sa_addr  <= i_init_addr;
         o_sa_data  <= i_init_data;
         o_sa_wen   <= i_init_wen;
         o_sa_wmask <= i_init_wmask;
         o_sa_valid <= i_init_valid;
      end else if (upd_grant_c) begin
         o_sa_addr  <= i_upd_addr;
         o_sa_data  <= i_upd_data;
         o_sa_wen   <= 1'b1;
         o_sa_wmask <= i_upd_wmask;
         o_sa_valid <= 1'b1;
      end else if (lkp_grant_c) begin
         o_sa_addr  <= i_lkp_addr;
         o_sa_data  <= '0;
         o_sa_wen   <= 1'b0;
         o_sa_wmask <= '0;
         o_sa_valid <= 1'b1;
      end else begin
         o_sa_addr  <= '0;
         o_sa_data  <= '0;
         o_sa_wen   <= 1'b0;
         o_sa_wmask <= '0;
         o_sa_valid <= 1'b0;
      end
   end

   // Two-stage read tracker: command cycle, then array data cycle; not frozen by halt.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_issued_q  <= 1'b0;
         lkp_rvalid_q <= 1'b0;
      end else begin
         rd_issued_q  <= lkp_grant_c;
         lkp_rvalid_q <= rd_issued_q;
      end
   end

   assign o_lkp_rvalid = lkp_rvalid_q;
   assign o_lkp_rdata  = lkp_rvalid_q ? i_sa_rdata : '0;

endmodule : status_array_arbiter
